lenet_conv_channel_mc: RTL and testbench

Parametrised multi-input-channel LeNet output channel. It computes one output feature map from IN_CH parallel input maps: per-channel KxK valid convolution, summed across channels, plus bias, arithmetic shift, ReLU or signed clamp, then optional 2x2/stride-2 maxpool. Weights and bias are written over a host write port, not a fixed ROM. The block targets C1 (IN_CH=1) and C3-style (IN_CH=6) layers of the LeNet pipeline.

---
 rtl/lenet_conv_channel_mc_if.sv | 32 +++
 rtl/lenet_conv_channel_mc.sv | 213 +++++++++++++++++++++
 tb/tb_lenet_conv_channel_mc.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/lenet_conv_channel_mc_if.sv
// Host/stream bundle for lenet_conv_channel_mc: weight/bias write port, pixel
// stream in, quantised pixel stream out, frame status and FSM state for checkers.
interface lenet_conv_channel_mc_if #(
  parameter int IN_CH = 1,
  parameter int AW    = 5
);
  logic                  start;
  logic                  wt_wr_en;
  logic [AW-1:0]         wt_wr_addr;
  logic signed [7:0]     wt_wr_data;
  logic                  bias_wr_en;
  logic signed [31:0]    bias_wr_data;
  logic                  data_valid_in;
  logic [8*IN_CH-1:0]    pixel_in;
  logic                  data_valid_out;
  logic signed [7:0]     pixel_out;
  logic                  busy;
  logic                  layer_done;
  logic [1:0]            state_dbg;

  modport master (
    output start, wt_wr_en, wt_wr_addr, wt_wr_data, bias_wr_en, bias_wr_data,
           data_valid_in, pixel_in,
    input  data_valid_out, pixel_out, busy, layer_done, state_dbg
  );

  modport slave (
    input  start, wt_wr_en, wt_wr_addr, wt_wr_data, bias_wr_en, bias_wr_data,
           data_valid_in, pixel_in,
    output data_valid_out, pixel_out, busy, layer_done, state_dbg
  );
endinterface

// File: rtl/lenet_conv_channel_mc.sv
// One LeNet output channel: IN_CH-input KxK valid convolution, bias, shift,
// ReLU/signed clamp and optional 2x2 maxpool, with host-writable weights.
module lenet_conv_channel_mc #(
  parameter int MAPSIZE      = 32,
  parameter int K            = 5,
  parameter int IN_CH        = 1,
  parameter int OUTPUT_SHIFT = 8,
  parameter int RELU_EN      = 1,
  parameter int POOL_EN      = 1
) (
  input logic                    clk,
  input logic                    rst,
  lenet_conv_channel_mc_if.slave bus
);
  // Handshake: data_valid_in and data_valid_out are bare valids with no ready.
  // A pixel is consumed in every RUN cycle where data_valid_in is high; an output
  // is delivered in every cycle data_valid_out is high and must be taken then.

  localparam int NW    = IN_CH * K * K;
  localparam int ACC_W = 17 + $clog2(NW);
  localparam int BW    = ((ACC_W > 32) ? ACC_W : 32) + 1;
  localparam int CW    = (MAPSIZE > 1) ? $clog2(MAPSIZE) : 1;
  localparam int CO    = MAPSIZE - K + 1;
  localparam int PO    = CO / 2;
  localparam int PW    = (PO > 1) ? $clog2(PO) : 1;
  localparam int N_OUT = (POOL_EN != 0) ? PO * PO : CO * CO;
  localparam int OCW   = $clog2(N_OUT + 1);
  localparam logic signed [BW-1:0] Q_HI = 127;
  localparam logic signed [BW-1:0] Q_LO = (RELU_EN != 0) ? 0 : -128;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic signed [7:0]    w    [NW];
  logic signed [31:0]   bias;
  logic signed [7:0]    lb   [IN_CH][K-1][MAPSIZE];
  logic signed [7:0]    win  [IN_CH][K][K];
  logic [CW-1:0]        row, col;
  logic                 accept, last_px, conv_hit;
  logic                 v1, v2, v3, pool_v;
  logic [CW-1:0]        r1, c1, r2, c2, r3, c3;
  logic signed [ACC_W-1:0] mac_sum;
  logic signed [BW-1:0] acc, shifted;
  logic signed [7:0]    q, q_px, hmax, pool_px, hpair, vpair;
  logic signed [7:0]    pbuf [PO];
  logic [PW-1:0]        pidx;
  logic                 pool_in, dv_out, last_out;
  logic [OCW-1:0]       out_cnt;

  assign accept   = (state == RUN) && bus.data_valid_in;
  assign last_px  = (row == CW'(MAPSIZE - 1)) && (col == CW'(MAPSIZE - 1));
  assign conv_hit = (row >= CW'(K - 1)) && (col >= CW'(K - 1));
  assign dv_out   = (POOL_EN != 0) ? pool_v : v3;
  assign last_out = (out_cnt == OCW'(N_OUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.busy       = 1'b0;
    bus.layer_done = 1'b0;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (accept && last_px) state_nx = DRAIN;
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (dv_out && last_out) state_nx = DONE;
      end
      DONE: begin
        bus.layer_done = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) w[i] <= '0;
      bias <= '0;
    end else if (state == IDLE) begin
      if (bus.wt_wr_en && (int'(bus.wt_wr_addr) < NW)) w[bus.wt_wr_addr] <= bus.wt_wr_data;
      if (bus.bias_wr_en) bias <= bus.bias_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (state != RUN) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == CW'(MAPSIZE - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // lb[ch][j] holds row (current-1-j); the window's rightmost column is loaded
  // from the new pixel plus the line buffers at the same column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < IN_CH; ch++) begin
        for (int j = 0; j < K - 1; j++)
          for (int x = 0; x < MAPSIZE; x++) lb[ch][j][x] <= '0;
        for (int rr = 0; rr < K; rr++)
          for (int cc = 0; cc < K; cc++) win[ch][rr][cc] <= '0;
      end
    end else if (accept) begin
      for (int ch = 0; ch < IN_CH; ch++) begin
        for (int rr = 0; rr < K; rr++)
          for (int cc = 0; cc < K - 1; cc++) win[ch][rr][cc] <= win[ch][rr][cc+1];
        win[ch][K-1][K-1] <= bus.pixel_in[8*ch +: 8];
        for (int j = 0; j < K - 1; j++) win[ch][K-2-j][K-1] <= lb[ch][j][col];
        lb[ch][0][col] <= bus.pixel_in[8*ch +: 8];
        for (int j = 1; j < K - 1; j++) lb[ch][j][col] <= lb[ch][j-1][col];
      end
    end
  end

  always_comb begin
    mac_sum = '0;
    for (int ch = 0; ch < IN_CH; ch++)
      for (int rr = 0; rr < K; rr++)
        for (int cc = 0; cc < K; cc++)
          mac_sum = mac_sum + ACC_W'(win[ch][rr][cc] * w[ch*K*K + rr*K + cc]);
  end

  // Bias add is one bit wider than both operands so it cannot wrap.
  always_comb begin
    shifted = acc >>> OUTPUT_SHIFT;
    if (shifted > Q_HI)      q = Q_HI[7:0];
    else if (shifted < Q_LO) q = Q_LO[7:0];
    else                     q = shifted[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      r1 <= '0; c1 <= '0; r2 <= '0; c2 <= '0; r3 <= '0; c3 <= '0;
      acc <= '0;
      q_px <= '0;
    end else begin
      v1 <= accept && conv_hit;
      v2 <= v1;
      v3 <= v2;
      if (accept && conv_hit) begin
        r1 <= row - CW'(K - 1);
        c1 <= col - CW'(K - 1);
      end
      if (v1) begin
        acc <= BW'(mac_sum) + BW'(bias);
        r2  <= r1;
        c2  <= c1;
      end
      if (v2) begin
        q_px <= q;
        r3   <= r2;
        c3   <= c2;
      end
    end
  end

  // Pool: even column parks in hmax, even row parks pair maxima in pbuf,
  // odd row/odd column closes the 2x2 block.
  assign pool_in = v3 && ({1'b0, r3} < (CW+1)'(2 * PO)) && ({1'b0, c3} < (CW+1)'(2 * PO));
  assign pidx    = PW'(c3 >> 1);
  assign hpair   = (q_px > hmax) ? q_px : hmax;
  assign vpair   = (pbuf[pidx] > hpair) ? pbuf[pidx] : hpair;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hmax    <= '0;
      pool_px <= '0;
      pool_v  <= 1'b0;
      for (int i = 0; i < PO; i++) pbuf[i] <= '0;
    end else begin
      pool_v <= 1'b0;
      if (pool_in) begin
        if (!c3[0]) begin
          hmax <= q_px;
        end else if (!r3[0]) begin
          pbuf[pidx] <= hpair;
        end else begin
          pool_px <= vpair;
          pool_v  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                out_cnt <= '0;
    else if (state == IDLE) out_cnt <= '0;
    else if (dv_out)        out_cnt <= out_cnt + 1'b1;
  end

  assign bus.data_valid_out = dv_out;
  assign bus.pixel_out      = (POOL_EN != 0) ? pool_px : q_px;
endmodule

// File: tb/tb_lenet_conv_channel_mc.sv
// Bench for lenet_conv_channel_mc: three instances (no pool/ReLU, pool/ReLU,
// no pool/signed clamp) share one stimulus stream; each has its own expected queue.
module tb_lenet_conv_channel_mc;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, wt_en, bias_en, dvin;
  logic [4:0]  wt_addr;
  logic [7:0]  wt_data;
  logic [31:0] bias_data;
  logic [15:0] pixel_in;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [39:0] exp_q [3][$];
  logic [39:0] e;
  int          last_out [3];
  logic [2:0]  done_seen;
  logic [2:0]  dv, ld, bz;
  logic [7:0]  px [3];
  logic [1:0]  st [3];

  lenet_conv_channel_mc_if #(.IN_CH(2), .AW(5)) bus_a ();
  lenet_conv_channel_mc_if #(.IN_CH(2), .AW(5)) bus_b ();
  lenet_conv_channel_mc_if #(.IN_CH(2), .AW(5)) bus_c ();

  lenet_conv_channel_mc #(.MAPSIZE(8), .K(3), .IN_CH(2), .OUTPUT_SHIFT(0), .RELU_EN(1), .POOL_EN(0))
    u_a (.clk(clk), .rst(rst), .bus(bus_a));
  lenet_conv_channel_mc #(.MAPSIZE(8), .K(3), .IN_CH(2), .OUTPUT_SHIFT(0), .RELU_EN(1), .POOL_EN(1))
    u_b (.clk(clk), .rst(rst), .bus(bus_b));
  lenet_conv_channel_mc #(.MAPSIZE(8), .K(3), .IN_CH(2), .OUTPUT_SHIFT(0), .RELU_EN(0), .POOL_EN(0))
    u_c (.clk(clk), .rst(rst), .bus(bus_c));

  assign bus_a.start = start;   assign bus_b.start = start;   assign bus_c.start = start;
  assign bus_a.wt_wr_en = wt_en; assign bus_b.wt_wr_en = wt_en; assign bus_c.wt_wr_en = wt_en;
  assign bus_a.wt_wr_addr = wt_addr; assign bus_b.wt_wr_addr = wt_addr; assign bus_c.wt_wr_addr = wt_addr;
  assign bus_a.wt_wr_data = wt_data; assign bus_b.wt_wr_data = wt_data; assign bus_c.wt_wr_data = wt_data;
  assign bus_a.bias_wr_en = bias_en; assign bus_b.bias_wr_en = bias_en; assign bus_c.bias_wr_en = bias_en;
  assign bus_a.bias_wr_data = bias_data; assign bus_b.bias_wr_data = bias_data; assign bus_c.bias_wr_data = bias_data;
  assign bus_a.data_valid_in = dvin; assign bus_b.data_valid_in = dvin; assign bus_c.data_valid_in = dvin;
  assign bus_a.pixel_in = pixel_in; assign bus_b.pixel_in = pixel_in; assign bus_c.pixel_in = pixel_in;

  assign dv = {bus_c.data_valid_out, bus_b.data_valid_out, bus_a.data_valid_out};
  assign ld = {bus_c.layer_done, bus_b.layer_done, bus_a.layer_done};
  assign bz = {bus_c.busy, bus_b.busy, bus_a.busy};
  assign px[0] = bus_a.pixel_out; assign px[1] = bus_b.pixel_out; assign px[2] = bus_c.pixel_out;
  assign st[0] = bus_a.state_dbg; assign st[1] = bus_b.state_dbg; assign st[2] = bus_c.state_dbg;

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus tables: scn 0 ramp/centre tap, 1 constants/all-ones, 2 saturate, 3 negative bias
  function automatic logic [7:0] pix(input int scn, input int ch, input int r, input int c);
    if (scn == 0)      return 8'(r * 8 + c);
    else if (scn == 1) return (ch == 0) ? 8'd10 : 8'd5;
    else               return 8'd100;
  endfunction

  function automatic logic [7:0] wval(input int scn, input int i);
    if (scn == 0)      return (i == 4) ? 8'd1 : 8'd0;
    else if (scn == 1) return 8'd1;
    else               return (i < 9) ? 8'd1 : 8'd0;
  endfunction

  function automatic logic [31:0] bval(input int scn);
    if (scn == 1)      return -32'sd100;
    else if (scn == 3) return -32'sd2000;
    else               return 32'd0;
  endfunction

  // Hand-derived results per conv position (i,j); dut 2 is the signed-clamp instance
  function automatic logic [7:0] exp_val(input int scn, input int i, input int j, input int k);
    if (scn == 0)      return 8'(8 * (i + 1) + (j + 1));
    else if (scn == 1) return 8'd35;
    else if (scn == 2) return 8'd127;
    else               return (k == 2) ? 8'h80 : 8'h00;
  endfunction

  // Driver tasks
  task automatic load(input int scn);
    for (int i = 0; i < 18; i++) begin
      wt_en = 1'b1; wt_addr = 5'(i); wt_data = wval(scn, i);
      @(posedge clk); #1;
    end
    wt_en = 1'b0;
    bias_en = 1'b1; bias_data = bval(scn);
    @(posedge clk); #1;
    bias_en = 1'b0;
  endtask

  task automatic run_frame(input int scn, input bit gaps, input bit poke, input int abort_at);
    int r, c;
    done_seen = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_in_run", int'(bz[0]), 1);
    for (int idx = 0; idx < 64; idx++) begin
      r = idx / 8;
      c = idx % 8;
      if (gaps) begin
        dvin = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      if (idx == abort_at) begin
        dvin = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("rst_valid_%0d", k), int'(dv[k]), 0);
          chk($sformatf("rst_pixel_%0d", k), int'(px[k]), 0);
          chk($sformatf("rst_busy_%0d", k), int'(bz[k]), 0);
          chk($sformatf("rst_state_%0d", k), int'(st[k]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) exp_q[k].delete();
        return;
      end
      dvin = 1'b1;
      pixel_in = {pix(scn, 1, r, c), pix(scn, 0, r, c)};
      if (r >= 2 && c >= 2) begin
        exp_q[0].push_back({32'(cyc + 3), exp_val(scn, r - 2, c - 2, 0)});
        exp_q[2].push_back({32'(cyc + 3), exp_val(scn, r - 2, c - 2, 2)});
        if (((r - 2) % 2 == 1) && ((c - 2) % 2 == 1))
          exp_q[1].push_back({32'(cyc + 4), exp_val(scn, r - 2, c - 2, 1)});
      end
      if (poke && idx == 20) begin
        start = 1'b1;
        wt_en = 1'b1; wt_addr = 5'd0; wt_data = 8'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
      wt_en = 1'b0;
    end
    dvin = 1'b0;
    for (int t = 0; t < 40 && done_seen != 3'b111; t++) begin @(posedge clk); #1; end
    chk("frame_done", int'(done_seen == 3'b111), 1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (dv[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("unexpected_out_%0d", k), int'(dv[k]), 0);
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("pixel_out_%0d", k), int'($signed(px[k])), int'($signed(e[7:0])));
            chk($sformatf("out_cycle_%0d", k), cyc, int'(e[39:8]));
          end
          last_out[k] = cyc;
        end
        if (ld[k]) begin
          chk($sformatf("outs_left_at_done_%0d", k), exp_q[k].size(), 0);
          chk($sformatf("done_latency_%0d", k), cyc - last_out[k], 1);
          chk($sformatf("busy_at_done_%0d", k), int'(bz[k]), 0);
          done_seen[k] = 1'b1;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0; wt_en = 1'b0; bias_en = 1'b0; dvin = 1'b0;
    wt_addr = '0; wt_data = '0; bias_data = '0; pixel_in = '0;
    done_seen = '0;
    for (int k = 0; k < 3; k++) last_out[k] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_valid_%0d", k), int'(dv[k]), 0);
      chk($sformatf("reset_pixel_%0d", k), int'(px[k]), 0);
      chk($sformatf("reset_done_%0d", k), int'(ld[k]), 0);
      chk($sformatf("reset_state_%0d", k), int'(st[k]), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    load(0); run_frame(0, 1'b0, 1'b0, -1);
    load(1); run_frame(1, 1'b0, 1'b0, -1);
    load(2); run_frame(2, 1'b0, 1'b0, -1);
    load(3); run_frame(3, 1'b0, 1'b0, -1);
    // Throttled input with ignored start and dropped weight write, then back-to-back frame
    load(1); run_frame(1, 1'b1, 1'b1, -1);
    run_frame(1, 1'b1, 1'b0, -1);
    // Reset mid-frame, reload and re-run
    load(0); run_frame(0, 1'b0, 1'b0, 30);
    load(0); run_frame(0, 1'b0, 1'b0, -1);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
